// File: rtl/contador_universal_if.sv
// Control and status bundle of contador_universal: the master drives the
// count controls, the slave (the counter) returns count, strobes and wraps.
interface contador_universal_if #(
    parameter int ANCHO         = 5,
    parameter int VUELTAS_ANCHO = 8
);
    logic                     enable;
    logic                     up_down;
    logic                     load;
    logic [ANCHO-1:0]         load_value;
    logic [ANCHO-1:0]         count;
    logic                     wrap;
    logic                     load_err;
    logic [VUELTAS_ANCHO-1:0] vueltas;

    modport master (
        output enable, up_down, load, load_value,
        input  count, wrap, load_err, vueltas
    );

    modport slave (
        input  enable, up_down, load, load_value,
        output count, wrap, load_err, vueltas
    );
endinterface

// File: rtl/contador_universal.sv
// Modulo-N up/down counter with synchronous load, prescaler and wrap strobe.
// Optional saturating wrap counter enabled by CONTADOR_UNIVERSAL_VUELTAS_EN.
module contador_universal #(
    parameter int ANCHO         = 5,
    parameter int MODULO        = 28,
    parameter int DIV           = 1,
    parameter int VUELTAS_ANCHO = 8
) (
    input  logic          clk,
    input  logic          rst,
    contador_universal_if.slave bus
);
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    // MODULO may equal 2**ANCHO, so the range check needs one extra bit.
    localparam logic [ANCHO:0]   MOD_W  = (ANCHO+1)'(MODULO);
    localparam logic [ANCHO-1:0] MAX_C  = ANCHO'(MODULO - 1);
    localparam logic [PRE_W-1:0] DIV_M1 = PRE_W'(DIV - 1);

    logic [ANCHO-1:0] count_q, count_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;
    logic             tick_s;

    // Next-state: load beats enable, enable beats hold.
    always_comb begin
        count_d    = count_q;
        pre_d      = pre_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        tick_s     = bus.enable && (pre_q == DIV_M1);
        if (bus.load) begin
            pre_d = '0;
            if ({1'b0, bus.load_value} < MOD_W) begin
                count_d = bus.load_value;
            end else begin
                count_d    = MAX_C;
                load_err_d = 1'b1;
            end
        end else if (bus.enable) begin
            pre_d = tick_s ? '0 : pre_q + PRE_W'(1);
            if (tick_s) begin
                if (bus.up_down) begin
                    if (count_q == MAX_C) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q + ANCHO'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        count_d = MAX_C;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q - ANCHO'(1);
                    end
                end
            end else begin
                count_d = count_q;
            end
        end else begin
            pre_d = pre_q;
        end
    end

    // Counter, prescaler and strobe registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= '0;
            pre_q      <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            pre_q      <= pre_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;

`ifdef CONTADOR_UNIVERSAL_VUELTAS_EN
    localparam logic [VUELTAS_ANCHO-1:0] V_MAX = '1;

    logic [VUELTAS_ANCHO-1:0] vueltas_q, vueltas_d;

    // Saturating wrap count, cleared by load.
    always_comb begin
        vueltas_d = vueltas_q;
        if (bus.load) begin
            vueltas_d = '0;
        end else if (wrap_d && (vueltas_q != V_MAX)) begin
            vueltas_d = vueltas_q + VUELTAS_ANCHO'(1);
        end else begin
            vueltas_d = vueltas_q;
        end
    end

    // Wrap counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vueltas_q <= '0;
        end else begin
            vueltas_q <= vueltas_d;
        end
    end

    assign bus.vueltas = vueltas_q;
`else
    assign bus.vueltas = '0;
`endif
endmodule

// File: tb/tb_contador_universal.sv
// Self-checking bench: two counters (DIV=1 and DIV=4) driven identically and
// compared every cycle against an arithmetic model, plus directed literals.
module tb_contador_universal;
    localparam int MOD = 28;
`ifdef CONTADOR_UNIVERSAL_VUELTAS_EN
    localparam int VMAX1 = 3;
    localparam int VMAX4 = 255;
`else
    localparam int VMAX1 = 0;
    localparam int VMAX4 = 0;
`endif

    typedef struct {
        int cnt;
        int pre;
        int wrap;
        int lerr;
        int v;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       ud  = 1'b1;
    logic       ld  = 1'b0;
    logic [4:0] lv  = 5'd0;
    bit         chk_on = 1'b0;
    int         n_chk  = 0;
    int         n_fail = 0;
    mdl_t       m1 = '{0, 0, 0, 0, 0};
    mdl_t       m4 = '{0, 0, 0, 0, 0};

    always #5 clk = ~clk;

    contador_universal_if #(.ANCHO(5), .VUELTAS_ANCHO(2)) if1 ();
    contador_universal_if #(.ANCHO(5), .VUELTAS_ANCHO(8)) if4 ();

    assign if1.enable = en;  assign if1.up_down = ud;
    assign if1.load   = ld;  assign if1.load_value = lv;
    assign if4.enable = en;  assign if4.up_down = ud;
    assign if4.load   = ld;  assign if4.load_value = lv;

    contador_universal #(.ANCHO(5), .MODULO(MOD), .DIV(1), .VUELTAS_ANCHO(2))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    contador_universal #(.ANCHO(5), .MODULO(MOD), .DIV(4), .VUELTAS_ANCHO(8))
        u4 (.clk(clk), .rst(rst), .bus(if4));

    function automatic mdl_t mstep(mdl_t m, int modulo, int div, int vmax,
                                   bit e, bit u, bit l, int val);
        mdl_t n = m;
        n.wrap = 0;
        n.lerr = 0;
        if (l) begin
            n.pre = 0;
            n.v   = 0;
            if (val < modulo) n.cnt = val;
            else begin n.cnt = modulo - 1; n.lerr = 1; end
        end else if (e) begin
            n.pre = (m.pre + 1) % div;
            if (m.pre == div - 1) begin
                if (u) begin
                    n.cnt  = (m.cnt + 1) % modulo;
                    n.wrap = (m.cnt == modulo - 1) ? 1 : 0;
                end else begin
                    n.cnt  = (m.cnt + modulo - 1) % modulo;
                    n.wrap = (m.cnt == 0) ? 1 : 0;
                end
                if (n.wrap == 1 && m.v < vmax) n.v = m.v + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m1 = '{0, 0, 0, 0, 0};
            m4 = '{0, 0, 0, 0, 0};
        end else begin
            m1 = mstep(m1, MOD, 1, VMAX1, en, ud, ld, int'(lv));
            m4 = mstep(m4, MOD, 4, VMAX4, en, ud, ld, int'(lv));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("u1.count",    32'(if1.count),    32'(m1.cnt));
            chk("u1.wrap",     32'(if1.wrap),     32'(m1.wrap));
            chk("u1.load_err", 32'(if1.load_err), 32'(m1.lerr));
            chk("u1.vueltas",  32'(if1.vueltas),  32'(m1.v));
            chk("u4.count",    32'(if4.count),    32'(m4.cnt));
            chk("u4.wrap",     32'(if4.wrap),     32'(m4.wrap));
            chk("u4.load_err", 32'(if4.load_err), 32'(m4.lerr));
            chk("u4.vueltas",  32'(if4.vueltas),  32'(m4.v));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1 rst = 1'b0;
        #1 chk_on = 1'b1;
        cyc(2);
        chk("rst count", 32'(if1.count), 32'd0);
        chk("rst wrap",  32'(if1.wrap),  32'd0);
        chk("rst u4",    32'(if4.count), 32'd0);
        rst = 1'b1; en = 1'b1; ud = 1'b1;
        // Up count over a full period.
        cyc(1);  chk("up first", 32'(if1.count), 32'd1);
        cyc(26); chk("up 27",    32'(if1.count), 32'd27);
        chk("up 27 wrap", 32'(if1.wrap), 32'd0);
        cyc(1);  chk("up wrap cnt", 32'(if1.count), 32'd0);
        chk("up wrap", 32'(if1.wrap), 32'd1);
        chk("div4 after 28", 32'(if4.count), 32'd7);
        cyc(1);  chk("after wrap", 32'(if1.count), 32'd1);
        chk("after wrap w", 32'(if1.wrap), 32'd0);
        cyc(111);
        chk("5 wraps cnt", 32'(if1.count), 32'd0);
        chk("5 wraps vueltas", 32'(if1.vueltas), 32'(VMAX1));
        // Load, clamp.
        ld = 1'b1; lv = 5'd5;
        cyc(1); chk("load 5", 32'(if1.count), 32'd5);
        chk("load clr vueltas", 32'(if1.vueltas), 32'd0);
        lv = 5'd10;
        cyc(1); chk("load 10", 32'(if1.count), 32'd10);
        ld = 1'b0;
        cyc(1); chk("after load", 32'(if1.count), 32'd11);
        chk("u4 load no tick", 32'(if4.count), 32'd10);
        ld = 1'b1; lv = 5'd30;
        cyc(1); chk("clamp", 32'(if1.count), 32'd27);
        chk("clamp err", 32'(if1.load_err), 32'd1);
        ld = 1'b0;
        cyc(1); chk("clamp err clr", 32'(if1.load_err), 32'd0);
        chk("clamp then wrap", 32'(if1.wrap), 32'd1);
        // Prescaler on u4.
        ld = 1'b1; lv = 5'd0;
        cyc(1); ld = 1'b0;
        cyc(3); chk("div4 edge3", 32'(if4.count), 32'd0);
        cyc(1); chk("div4 edge4", 32'(if4.count), 32'd1);
        cyc(2); en = 1'b0;
        cyc(3); chk("div4 hold", 32'(if4.count), 32'd1);
        en = 1'b1;
        cyc(1); chk("div4 delayed", 32'(if4.count), 32'd1);
        cyc(1); chk("div4 step", 32'(if4.count), 32'd2);
        cyc(2); ld = 1'b1; lv = 5'd0;
        cyc(1); ld = 1'b0;
        cyc(3); chk("div4 restart3", 32'(if4.count), 32'd0);
        cyc(1); chk("div4 restart4", 32'(if4.count), 32'd1);
        // Asynchronous reset between edges.
        ld = 1'b1; lv = 5'd15;
        cyc(1); ld = 1'b0;
        chk("load 15", 32'(if1.count), 32'd15);
        #2 rst = 1'b0;
        #1 chk("async cnt", 32'(if1.count), 32'd0);
        chk("async wrap", 32'(if1.wrap), 32'd0);
        chk("async u4", 32'(if4.count), 32'd0);
        cyc(1); rst = 1'b1;
        cyc(1); chk("resume", 32'(if1.count), 32'd1);
        // Down count from reset, then direction toggling at the boundary.
        ud = 1'b0; rst = 1'b0;
        cyc(1); rst = 1'b1;
        cyc(1); chk("down first", 32'(if1.count), 32'd27);
        chk("down wrap", 32'(if1.wrap), 32'd1);
        cyc(1); chk("down 26", 32'(if1.count), 32'd26);
        chk("down 26 w", 32'(if1.wrap), 32'd0);
        ud = 1'b1;
        cyc(2); chk("toggle up wrap", 32'(if1.count), 32'd0);
        ud = 1'b0;
        cyc(1); chk("toggle dn cnt", 32'(if1.count), 32'd27);
        chk("toggle dn wrap", 32'(if1.wrap), 32'd1);
        en = 1'b0;
        cyc(1); chk("disable hold", 32'(if1.count), 32'd27);
        chk("disable wrap", 32'(if1.wrap), 32'd0);
        cyc(2);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
